melody_player: RTL and testbench



---
 rtl/buzzer_pkg.sv | 30 +++
 rtl/melody_player_if.sv | 30 +++
 rtl/melody_player_square_tone.sv | 30 +++
 rtl/melody_player.sv | 155 +++++++++++++++
 tb/tb_melody_player.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer / melody player family.
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    localparam int unsigned DEF_HALF_W      = 22;
    localparam int unsigned DEF_DUR_W       = 4;
    localparam int unsigned DEF_BEAT_CYCLES = 25_000_000;
    localparam int unsigned DEF_GAP_CYCLES  = 1_000_000;

    // Square-wave half-periods in clocks at 100 MHz.
    localparam int unsigned HALF_C4 = 191_113;
    localparam int unsigned HALF_D4 = 170_262;
    localparam int unsigned HALF_E4 = 151_686;
    localparam int unsigned HALF_F4 = 143_172;
    localparam int unsigned HALF_G4 = 127_551;
    localparam int unsigned HALF_A4 = 113_636;
    localparam int unsigned HALF_B4 = 101_239;
    localparam int unsigned HALF_C5 = 95_556;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned width_for(input longint unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/melody_player_if.sv
// Control, table-write and output signals of the melody player.
interface melody_player_if #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned HALF_W = 22,
    parameter int unsigned DUR_W  = 4
) ();

    logic              start;
    logic              stop;
    logic              loop_en;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [HALF_W-1:0] wr_half;
    logic [DUR_W-1:0]  wr_dur;
    logic              sound;
    logic              busy;
    logic [IDX_W-1:0]  note_idx;
    logic              done;

    modport master (
        output start, stop, loop_en, wr_en, wr_addr, wr_half, wr_dur,
        input  sound, busy, note_idx, done
    );

    modport slave (
        input  start, stop, loop_en, wr_en, wr_addr, wr_half, wr_dur,
        output sound, busy, note_idx, done
    );

endinterface

// File: rtl/melody_player_square_tone.sv
// Square-wave generator: toggles sound every `half` clocks; half==0 is silence.
module square_tone
    import buzzer_pkg::*;
#(
    parameter int unsigned HALF_W = DEF_HALF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [HALF_W-1:0] half,
    output logic              sound
);

    logic [HALF_W-1:0] tone_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tone_cnt <= '0;
            sound    <= 1'b0;
        end else if (half != '0) begin
            if (tone_cnt == half - HALF_W'(1)) begin
                tone_cnt <= '0;
                sound    <= ~sound;
            end else begin
                tone_cnt <= tone_cnt + HALF_W'(1);
            end
        end
    end

endmodule

// File: rtl/melody_player.sv
// Table-driven melody sequencer with rests, articulation gap, end marker and loop.
module melody_player
    import buzzer_pkg::*;
#(
    parameter int unsigned NUM_NOTES   = 16,
    parameter int unsigned HALF_W      = DEF_HALF_W,
    parameter int unsigned DUR_W       = DEF_DUR_W,
    parameter int unsigned BEAT_CYCLES = DEF_BEAT_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned IDX_W       = $clog2(NUM_NOTES)
) (
    input  logic            clk,
    input  logic            rst,
    melody_player_if.slave  bus
);

    localparam int unsigned CYC_W = width_for(BEAT_CYCLES);
    localparam int unsigned GAP_W = width_for(GAP_CYCLES);

    logic [HALF_W-1:0] tbl_half [NUM_NOTES];
    logic [DUR_W-1:0]  tbl_dur  [NUM_NOTES];

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx_q;
    logic [HALF_W-1:0] cur_half;
    logic [DUR_W-1:0]  cur_dur;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [DUR_W-1:0]  beat_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              done_q;

    logic              last_beat, gap_last;
    logic              advance, wrap, want_load, load, finish;
    logic [IDX_W-1:0]  want_addr, load_addr;
    logic              tone_clear, tone_out;

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            tbl_half[bus.wr_addr] <= bus.wr_half;
            tbl_dur[bus.wr_addr]  <= bus.wr_dur;
        end
    end

    // Duration is counted as cycles-within-beat times beats, avoiding a wide product.
    assign last_beat = (cyc_cnt == CYC_W'(BEAT_CYCLES - 1)) &&
                       (beat_cnt == cur_dur - DUR_W'(1));
    assign gap_last  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    always_comb begin
        state_n   = state;
        advance   = 1'b0;
        wrap      = 1'b0;
        want_load = 1'b0;
        want_addr = '0;
        load      = 1'b0;
        load_addr = '0;
        finish    = 1'b0;

        case (state)
            IDLE: if (bus.start && !bus.stop) want_load = 1'b1;
            PLAY: begin
                if (last_beat) begin
                    if (GAP_CYCLES == 0) advance = 1'b1;
                    else                 state_n = GAP;
                end
            end
            GAP:  if (gap_last) advance = 1'b1;
            default: state_n = IDLE;
        endcase

        if (advance) begin
            if (idx_q == IDX_W'(NUM_NOTES - 1)) begin
                wrap = 1'b1;
            end else begin
                want_load = 1'b1;
                want_addr = idx_q + IDX_W'(1);
            end
        end

        // End of melody: a marker or running off the table; looping never
        // re-enters a marker at index 0, so a dur-0 first entry always finishes.
        if (want_load && tbl_dur[want_addr] != '0) begin
            load      = 1'b1;
            load_addr = want_addr;
        end else if (want_load || wrap) begin
            if (bus.loop_en && (wrap || want_addr != '0) && tbl_dur[0] != '0) begin
                load      = 1'b1;
                load_addr = '0;
            end else begin
                finish = 1'b1;
            end
        end

        if (load)   state_n = PLAY;
        if (finish) state_n = IDLE;

        if (bus.stop && state != IDLE) begin
            state_n = IDLE;
            load    = 1'b0;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx_q    <= '0;
            cur_half <= '0;
            cur_dur  <= '0;
            cyc_cnt  <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= finish;
            if (load) begin
                idx_q    <= load_addr;
                cur_half <= tbl_half[load_addr];
                cur_dur  <= tbl_dur[load_addr];
                cyc_cnt  <= '0;
                beat_cnt <= '0;
                gap_cnt  <= '0;
            end else if (state == PLAY) begin
                gap_cnt <= '0;
                if (cyc_cnt == CYC_W'(BEAT_CYCLES - 1)) begin
                    cyc_cnt  <= '0;
                    beat_cnt <= beat_cnt + DUR_W'(1);
                end else begin
                    cyc_cnt <= cyc_cnt + CYC_W'(1);
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

    assign tone_clear = load || (state_n != PLAY);

    square_tone #(
        .HALF_W (HALF_W)
    ) u_tone (
        .clk   (clk),
        .rst   (rst),
        .clear (tone_clear),
        .half  (cur_half),
        .sound (tone_out)
    );

    assign bus.sound    = tone_out;
    assign bus.busy     = (state != IDLE);
    assign bus.note_idx = idx_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_melody_player.sv
// Self-checking bench for melody_player against a cycle-list reference model.
module tb_melody_player;

    localparam int NN     = 4;
    localparam int IDX_W  = 2;
    localparam int HALF_W = 22;
    localparam int DUR_W  = 4;
    localparam int BEAT   = 8;
    localparam int GAPC   = 2;

    typedef struct {
        logic s;
        logic b;
        int   idx;
        logic d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    int   ta_half [NN];
    int   ta_dur  [NN];
    int   tb_half [NN];
    int   tb_dur  [NN];
    exp_t exp_q [$];

    melody_player_if #(.IDX_W(IDX_W), .HALF_W(HALF_W), .DUR_W(DUR_W)) bus ();

    melody_player #(
        .NUM_NOTES   (NN),
        .HALF_W      (HALF_W),
        .DUR_W       (DUR_W),
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push(input logic s, input logic b, input int idx, input logic d);
        exp_t e;
        e.s = s; e.b = b; e.idx = idx; e.d = d;
        exp_q.push_back(e);
    endfunction

    // Expected outputs per cycle after the start edge, built note by note from
    // the table: a note started at cycle >= sw sees table B, earlier ones table A.
    task automatic build_model(input bit loop, input int n, input int sw, input int idx0);
        int i, last, c, h, d, d0;
        bit fin;
        i = 0; last = idx0; fin = 0;
        exp_q.delete();
        while (exp_q.size() < n && !fin) begin
            c = exp_q.size();
            h = (c >= sw) ? tb_half[i] : ta_half[i];
            d = (c >= sw) ? tb_dur[i]  : ta_dur[i];
            d0 = (c >= sw) ? tb_dur[0] : ta_dur[0];
            if (d == 0) begin
                if (loop && i != 0 && d0 != 0) i = 0;
                else fin = 1;
            end else begin
                for (int k = 0; k < d * BEAT; k++)
                    push((h == 0) ? 1'b0 : 1'(((k / h) % 2)), 1'b1, i, 1'b0);
                for (int g = 0; g < GAPC; g++) push(1'b0, 1'b1, i, 1'b0);
                last = i;
                if (i == NN - 1) begin
                    d0 = (exp_q.size() >= sw) ? tb_dur[0] : ta_dur[0];
                    if (loop && d0 != 0) i = 0;
                    else fin = 1;
                end else begin
                    i++;
                end
            end
        end
        if (fin) push(1'b0, 1'b0, last, 1'b1);
        while (exp_q.size() < n) push(1'b0, 1'b0, last, 1'b0);
    endtask

    task automatic write_entry(input int a, input int h, input int d);
        bus.wr_en = 1'b1; bus.wr_addr = IDX_W'(a);
        bus.wr_half = HALF_W'(h); bus.wr_dur = DUR_W'(d);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < NN; i++) begin
            write_entry(i, ta_half[i], ta_dur[i]);
            tb_half[i] = ta_half[i];
            tb_dur[i]  = ta_dur[i];
        end
    endtask

    task automatic basic_table();
        ta_half = '{3, 2, 0, 5};
        ta_dur  = '{1, 2, 1, 0};
        load_table();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.stop = 0; bus.loop_en = 0; bus.wr_en = 0;
        bus.wr_addr = '0; bus.wr_half = '0; bus.wr_dur = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_assert++; if (bus.sound !== 1'b0) begin n_fail++; $display("FAIL reset_sound: got %b want 0", bus.sound); end
        n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_assert++; if (bus.note_idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", bus.note_idx); end
        n_assert++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        basic_table();
        bus.loop_en = 1'b0;
        build_model(1'b0, 45, 1 << 30, 0);
        do_start();
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            n_assert++;
            if (bus.sound !== exp_q[c].s || bus.busy !== exp_q[c].b || bus.done !== exp_q[c].d ||
                bus.note_idx !== IDX_W'(exp_q[c].idx)) begin
                n_fail++;
                $display("FAIL basic c%0d: s/b/d/idx=%b/%b/%b/%0d want %b/%b/%b/%0d", c, bus.sound,
                         bus.busy, bus.done, bus.note_idx, exp_q[c].s, exp_q[c].b, exp_q[c].d, exp_q[c].idx);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_loop();
        ta_half = '{4, 4, 4, 4};
        ta_dur  = '{1, 1, 1, 1};
        load_table();
        bus.loop_en = 1'b1;
        build_model(1'b1, 60, 1 << 30, 0);
        do_start();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            n_assert++;
            if (bus.sound !== exp_q[c].s || bus.busy !== exp_q[c].b || bus.done !== exp_q[c].d ||
                bus.note_idx !== IDX_W'(exp_q[c].idx)) begin
                n_fail++;
                $display("FAIL loop c%0d: s/b/d/idx=%b/%b/%b/%0d want %b/%b/%b/%0d", c, bus.sound,
                         bus.busy, bus.done, bus.note_idx, exp_q[c].s, exp_q[c].b, exp_q[c].d, exp_q[c].idx);
            end
            @(posedge clk); #1;
        end
        do_stop();
        bus.loop_en = 1'b0;
    endtask

    task automatic test_stop();
        basic_table();
        bus.loop_en = 1'b0;
        build_model(1'b0, 16, 1 << 30, 0);
        do_start();
        for (int c = 0; c < 16; c++) begin
            if (c == 15) begin bus.stop = 1'b1; bus.start = 1'b1; end
            @(negedge clk);
            n_assert++;
            if (bus.sound !== exp_q[c].s || bus.busy !== exp_q[c].b || bus.note_idx !== IDX_W'(exp_q[c].idx)) begin
                n_fail++;
                $display("FAIL stop_pre c%0d: s/b/idx=%b/%b/%0d want %b/%b/%0d", c, bus.sound, bus.busy,
                         bus.note_idx, exp_q[c].s, exp_q[c].b, exp_q[c].idx);
            end
            @(posedge clk); #1;
        end
        bus.stop = 1'b0; bus.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_assert++;
            if (bus.sound !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.note_idx !== IDX_W'(1)) begin
                n_fail++;
                $display("FAIL stop_after c%0d: s/b/d/idx=%b/%b/%b/%0d want 0/0/0/1", c, bus.sound,
                         bus.busy, bus.done, bus.note_idx);
            end
            @(posedge clk); #1;
        end
        bus.stop = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        n_assert++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stop_wins: busy=%b want 0", bus.busy); end
        @(posedge clk); #1;
        build_model(1'b0, 45, 1 << 30, 1);
        do_start();
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            n_assert++;
            if (bus.sound !== exp_q[c].s || bus.busy !== exp_q[c].b || bus.done !== exp_q[c].d ||
                bus.note_idx !== IDX_W'(exp_q[c].idx)) begin
                n_fail++;
                $display("FAIL stop_restart c%0d: s/b/d/idx=%b/%b/%b/%0d want %b/%b/%b/%0d", c, bus.sound,
                         bus.busy, bus.done, bus.note_idx, exp_q[c].s, exp_q[c].b, exp_q[c].d, exp_q[c].idx);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_end_marker0();
        ta_half = '{6, 3, 3, 3};
        ta_dur  = '{0, 1, 1, 1};
        load_table();
        bus.loop_en = 1'b1;
        build_model(1'b1, 6, 1 << 30, -1);
        do_start();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_assert++;
            if (bus.sound !== exp_q[c].s || bus.busy !== exp_q[c].b || bus.done !== exp_q[c].d) begin
                n_fail++;
                $display("FAIL marker0 c%0d: s/b/d=%b/%b/%b want %b/%b/%b", c, bus.sound, bus.busy,
                         bus.done, exp_q[c].s, exp_q[c].b, exp_q[c].d);
            end
            @(posedge clk); #1;
        end
        bus.loop_en = 1'b0;
    endtask

    task automatic test_rewrite();
        ta_half = '{3, 2, 4, 1};
        ta_dur  = '{1, 1, 1, 1};
        load_table();
        tb_half[1] = 7;
        bus.loop_en = 1'b1;
        build_model(1'b1, 100, 15, 0);
        do_start();
        for (int c = 0; c < 100; c++) begin
            if (c == 13) begin
                bus.wr_en = 1'b1; bus.wr_addr = IDX_W'(1);
                bus.wr_half = HALF_W'(7); bus.wr_dur = DUR_W'(1);
            end
            @(negedge clk);
            n_assert++;
            if (bus.sound !== exp_q[c].s || bus.busy !== exp_q[c].b || bus.done !== exp_q[c].d ||
                bus.note_idx !== IDX_W'(exp_q[c].idx)) begin
                n_fail++;
                $display("FAIL rewrite c%0d: s/b/d/idx=%b/%b/%b/%0d want %b/%b/%b/%0d", c, bus.sound,
                         bus.busy, bus.done, bus.note_idx, exp_q[c].s, exp_q[c].b, exp_q[c].d, exp_q[c].idx);
            end
            @(posedge clk); #1;
            bus.wr_en = 1'b0;
        end
        do_stop();
        bus.loop_en = 1'b0;
    endtask

    task automatic test_rst_gap();
        basic_table();
        bus.loop_en = 1'b0;
        do_start();
        repeat (8) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (bus.sound !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.note_idx !== '0) begin
            n_fail++;
            $display("FAIL rst_gap: s/b/d/idx=%b/%b/%b/%0d want 0/0/0/0", bus.sound, bus.busy,
                     bus.done, bus.note_idx);
        end
        @(posedge clk); #1;
        build_model(1'b0, 45, 1 << 30, 0);
        do_start();
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            n_assert++;
            if (bus.sound !== exp_q[c].s || bus.busy !== exp_q[c].b || bus.done !== exp_q[c].d ||
                bus.note_idx !== IDX_W'(exp_q[c].idx)) begin
                n_fail++;
                $display("FAIL rst_replay c%0d: s/b/d/idx=%b/%b/%b/%0d want %b/%b/%b/%0d", c, bus.sound,
                         bus.busy, bus.done, bus.note_idx, exp_q[c].s, exp_q[c].b, exp_q[c].d, exp_q[c].idx);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int sp;
        bit lp;
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < NN; i++) begin
                ta_half[i] = $urandom_range(0, 5);
                ta_dur[i]  = (i == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            end
            load_table();
            lp = 1'($urandom_range(0, 1));
            bus.loop_en = lp;
            sp = $urandom_range(1, 7);
            build_model(lp, 120, 1 << 30, 0);
            do_start();
            for (int c = 0; c < 120; c++) begin
                bus.start = (c == sp);
                @(negedge clk);
                n_assert++;
                if (bus.sound !== exp_q[c].s || bus.busy !== exp_q[c].b || bus.done !== exp_q[c].d ||
                    bus.note_idx !== IDX_W'(exp_q[c].idx)) begin
                    n_fail++;
                    $display("FAIL random it%0d c%0d: s/b/d/idx=%b/%b/%b/%0d want %b/%b/%b/%0d", it, c,
                             bus.sound, bus.busy, bus.done, bus.note_idx,
                             exp_q[c].s, exp_q[c].b, exp_q[c].d, exp_q[c].idx);
                end
                @(posedge clk); #1;
            end
            bus.start = 1'b0;
            do_stop();
        end
        bus.loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop();
        test_stop();
        test_end_marker0();
        test_rewrite();
        test_rst_gap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
